// File: rtl/uart_rx_display.sv
// 8N1 UART receiver with sequential binary-to-BCD conversion driving three active-low 7-segment digits.
// RxValid one cycle after the stop sample, display 9 cycles later; no backpressure, every good byte is reported.
module uart_rx_display #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic        src_clk,
    input  logic        rst,
    input  logic        DataIn,
    output logic [7:0]  RxData,
    output logic        RxValid,
    output logic        FrameErr,
    output logic        Busy,
    output logic [20:0] Display_out
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        ARM,
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    rx_state_t   state;
    logic        rx_meta;
    logic        rx_s;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        stop_hit;

    logic        conv_busy;
    logic [3:0]  conv_cnt;
    logic [19:0] bcd;
    logic [19:0] bcd_adj;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Synchronizer resets to the idle level so ARM never sees a phantom start.
    always_ff @(posedge src_clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= DataIn;
            rx_s    <= rx_meta;
        end
    end

    assign stop_hit = (state == STOP) && (cnt == BIT_LAST);

    always_ff @(posedge src_clk) begin
        if (rst) begin
            state    <= ARM;
            cnt      <= 16'd0;
            bit_idx  <= 3'd0;
            shreg    <= 8'd0;
            RxData   <= 8'd0;
            RxValid  <= 1'b0;
            FrameErr <= 1'b0;
        end else begin
            RxValid  <= 1'b0;
            FrameErr <= 1'b0;
            case (state)
                ARM: begin
                    // A full bit time of idle line guarantees we are not mid-frame.
                    if (!rx_s) begin
                        cnt <= 16'd0;
                    end else if (cnt == BIT_LAST) begin
                        cnt   <= 16'd0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                IDLE: begin
                    cnt <= 16'd0;
                    if (!rx_s) begin
                        bit_idx <= 3'd0;
                        state   <= START;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= 16'd0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= 16'd0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= 16'd0;
                        if (rx_s) begin
                            RxData  <= shreg;
                            RxValid <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            FrameErr <= 1'b1;
                            state    <= ARM;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= ARM;
            endcase
        end
    end

    // Double-dabble add-3 step on the hundreds, tens and units nibbles.
    always_comb begin
        bcd_adj = bcd;
        if (bcd[11:8] >= 4'd5) begin
            bcd_adj[11:8] = bcd[11:8] + 4'd3;
        end
        if (bcd[15:12] >= 4'd5) begin
            bcd_adj[15:12] = bcd[15:12] + 4'd3;
        end
        if (bcd[19:16] >= 4'd5) begin
            bcd_adj[19:16] = bcd[19:16] + 4'd3;
        end
    end

    // conv_cnt 0..7 shift, 8 drives the display, 9 retires the conversion.
    always_ff @(posedge src_clk) begin
        if (rst) begin
            conv_busy   <= 1'b0;
            conv_cnt    <= 4'd0;
            bcd         <= 20'd0;
            Display_out <= 21'h1FFFFF;
        end else if (stop_hit && rx_s) begin
            bcd       <= {12'd0, shreg};
            conv_cnt  <= 4'd0;
            conv_busy <= 1'b1;
        end else if (conv_busy) begin
            if (conv_cnt < 4'd8) begin
                bcd      <= bcd_adj << 1;
                conv_cnt <= conv_cnt + 4'd1;
            end else if (conv_cnt == 4'd8) begin
                Display_out <= {seg7(bcd[19:16]), seg7(bcd[15:12]), seg7(bcd[11:8])};
                conv_cnt    <= 4'd9;
            end else begin
                conv_busy <= 1'b0;
            end
        end
    end

    assign Busy = conv_busy || (state == START) || (state == DATA) || (state == STOP);

endmodule

// File: tb/tb_uart_rx_display.sv
// Bench for uart_rx_display: UART driver, scoreboard monitor and per-scenario tasks.
module tb_uart_rx_display;

    localparam int CPB = 16;

    logic        src_clk = 1'b0;
    logic        rst     = 1'b1;
    logic        DataIn  = 1'b1;
    logic [7:0]  RxData;
    logic        RxValid;
    logic        FrameErr;
    logic        Busy;
    logic [20:0] Display_out;

    int          errors = 0;
    int          checks = 0;
    int          rv_count = 0;
    int          fe_count = 0;
    int          disp_cd = 0;
    logic        prev_valid = 1'b0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_e;
    logic [7:0]  model_rxdata = 8'h00;
    logic [20:0] model_disp = 21'h1FFFFF;
    logic [20:0] pend_disp = 21'h1FFFFF;

    always #5 src_clk = ~src_clk;

    uart_rx_display #(.CLKS_PER_BIT(CPB)) dut (
        .src_clk    (src_clk),
        .rst        (rst),
        .DataIn     (DataIn),
        .RxData     (RxData),
        .RxValid    (RxValid),
        .FrameErr   (FrameErr),
        .Busy       (Busy),
        .Display_out(Display_out)
    );

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [20:0] disp_of(input logic [7:0] b);
        int v;
        v = int'(b);
        return {seg_of(v / 100), seg_of((v / 10) % 10), seg_of(v % 10)};
    endfunction

    // Scoreboard monitor: pops expected bytes on RxValid and tracks display timing.
    always @(negedge src_clk) begin
        if (rst) begin
            disp_cd    = 0;
            prev_valid = 1'b0;
        end else begin
            if (disp_cd == 8) begin
                checks++;
                if (Display_out !== model_disp) begin
                    errors++;
                    $display("FAIL display_early: got %h expected %h", Display_out, model_disp);
                end
            end
            if (disp_cd == 9) begin
                model_disp = pend_disp;
                checks++;
                if (Display_out !== model_disp) begin
                    errors++;
                    $display("FAIL display_update: got %h expected %h", Display_out, model_disp);
                end
                checks++;
                if (Busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_converting: got %b expected 1", Busy);
                end
                disp_cd = 0;
            end else if (disp_cd != 0) begin
                disp_cd++;
            end
            if (RxValid || FrameErr) begin
                checks++;
                if (RxValid && FrameErr) begin
                    errors++;
                    $display("FAIL pulse_exclusive: RxValid=%b FrameErr=%b expected not both", RxValid, FrameErr);
                end
            end
            if (FrameErr) fe_count++;
            if (RxValid) begin
                rv_count++;
                checks++;
                if (prev_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rxvalid_width: previous cycle RxValid=%b expected 0", prev_valid);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rxvalid: got RxData=%h expected no byte", RxData);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (RxData !== mon_e) begin
                        errors++;
                        $display("FAIL rxdata: got %h expected %h", RxData, mon_e);
                    end
                    model_rxdata = mon_e;
                    pend_disp    = disp_of(mon_e);
                    disp_cd      = 1;
                end
            end
            prev_valid = RxValid;
        end
    end

    task automatic drive_level(input logic v, input int n);
        DataIn = v;
        repeat (n) @(posedge src_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit expect_byte);
        if (expect_byte) exp_q.push_back(b);
        drive_level(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_level(b[i], CPB);
        drive_level(stop_bit, CPB);
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (RxData !== 8'h00) begin errors++; $display("FAIL %s_rxdata: got %h expected 00", tag, RxData); end
        checks++;
        if (RxValid !== 1'b0) begin errors++; $display("FAIL %s_rxvalid: got %b expected 0", tag, RxValid); end
        checks++;
        if (FrameErr !== 1'b0) begin errors++; $display("FAIL %s_frameerr: got %b expected 0", tag, FrameErr); end
        checks++;
        if (Busy !== 1'b0) begin errors++; $display("FAIL %s_busy: got %b expected 0", tag, Busy); end
        checks++;
        if (Display_out !== 21'h1FFFFF) begin errors++; $display("FAIL %s_display: got %h expected 1fffff", tag, Display_out); end
    endtask

    task automatic check_received(input string tag, input int rv0, input int nbytes,
                                  input logic [7:0] byte_exp, input logic [20:0] disp_exp);
        @(negedge src_clk);
        checks++;
        if (rv_count - rv0 !== nbytes) begin errors++; $display("FAIL %s_count: got %0d expected %0d", tag, rv_count - rv0, nbytes); end
        checks++;
        if (RxData !== byte_exp) begin errors++; $display("FAIL %s_rxdata: got %h expected %h", tag, RxData, byte_exp); end
        checks++;
        if (Display_out !== disp_exp) begin errors++; $display("FAIL %s_display: got %h expected %h", tag, Display_out, disp_exp); end
        checks++;
        if (Busy !== 1'b0) begin errors++; $display("FAIL %s_busy_idle: got %b expected 0", tag, Busy); end
        @(posedge src_clk);
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        DataIn = 1'b1;
        repeat (3) @(posedge src_clk);
        @(negedge src_clk);
        check_reset_values("reset");
        @(posedge src_clk);
        #1;
        rst          = 1'b0;
        model_disp   = 21'h1FFFFF;
        model_rxdata = 8'h00;
        drive_level(1'b1, 24);
    endtask

    task automatic test_normal_byte();
        int rv0;
        rv0 = rv_count;
        send_frame(8'hE7, 1'b1, 1'b1);
        drive_level(1'b1, 12);
        check_received("normal", rv0, 1, 8'hE7, {7'b0100100, 7'b0110000, 7'b1111001});
    endtask

    task automatic test_back_to_back();
        int rv0;
        rv0 = rv_count;
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        drive_level(1'b1, 12);
        check_received("b2b", rv0, 2, 8'hFF, {7'b0100100, 7'b0010010, 7'b0010010});
    endtask

    task automatic test_start_glitch();
        int rv0;
        int fe0;
        bit saw_busy;
        bit fell;
        rv0      = rv_count;
        fe0      = fe_count;
        saw_busy = 1'b0;
        fell     = 1'b0;
        drive_level(1'b0, 4);
        DataIn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge src_clk);
            if (Busy) saw_busy = 1'b1;
            else if (saw_busy) begin
                fell = 1'b1;
                break;
            end
        end
        checks++;
        if (saw_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise: got %b expected 1", saw_busy); end
        checks++;
        if (fell !== 1'b1) begin errors++; $display("FAIL glitch_busy_fall: got %b expected 1 within 12 cycles", fell); end
        @(posedge src_clk);
        #1;
        drive_level(1'b1, 40);
        @(negedge src_clk);
        checks++;
        if (rv_count - rv0 !== 0) begin errors++; $display("FAIL glitch_rxvalid: got %0d expected 0", rv_count - rv0); end
        checks++;
        if (fe_count - fe0 !== 0) begin errors++; $display("FAIL glitch_frameerr: got %0d expected 0", fe_count - fe0); end
        checks++;
        if (Display_out !== model_disp) begin errors++; $display("FAIL glitch_display: got %h expected %h", Display_out, model_disp); end
        @(posedge src_clk);
        #1;
    endtask

    task automatic test_frame_error();
        int rv0;
        int fe0;
        rv0 = rv_count;
        fe0 = fe_count;
        send_frame(8'h55, 1'b0, 1'b0);
        drive_level(1'b1, 8);
        drive_level(1'b0, CPB);
        drive_level(1'b1, 200);
        @(negedge src_clk);
        checks++;
        if (fe_count - fe0 !== 1) begin errors++; $display("FAIL ferr_pulses: got %0d expected 1", fe_count - fe0); end
        checks++;
        if (rv_count - rv0 !== 0) begin errors++; $display("FAIL ferr_rxvalid: got %0d expected 0", rv_count - rv0); end
        checks++;
        if (RxData !== model_rxdata) begin errors++; $display("FAIL ferr_rxdata: got %h expected %h", RxData, model_rxdata); end
        checks++;
        if (Display_out !== model_disp) begin errors++; $display("FAIL ferr_display: got %h expected %h", Display_out, model_disp); end
        @(posedge src_clk);
        #1;
        rv0 = rv_count;
        send_frame(8'h2A, 1'b1, 1'b1);
        drive_level(1'b1, 12);
        check_received("after_ferr", rv0, 1, 8'h2A, {7'b1000000, 7'b0011001, 7'b0100100});
    endtask

    task automatic test_reset_mid_frame();
        int rv0;
        int fe0;
        drive_level(1'b0, CPB);
        drive_level(1'b1, CPB);
        drive_level(1'b0, CPB);
        drive_level(1'b0, CPB);
        drive_level(1'b0, 8);
        rst = 1'b1;
        @(posedge src_clk);
        #1;
        rst = 1'b0;
        @(negedge src_clk);
        check_reset_values("midrst");
        model_disp   = 21'h1FFFFF;
        model_rxdata = 8'h00;
        rv0 = rv_count;
        fe0 = fe_count;
        @(posedge src_clk);
        #1;
        drive_level(1'b0, 6);
        drive_level(1'b0, 3 * CPB);
        drive_level(1'b1, CPB);
        drive_level(1'b1, CPB);
        @(negedge src_clk);
        checks++;
        if (rv_count - rv0 !== 0) begin errors++; $display("FAIL midrst_rxvalid: got %0d expected 0", rv_count - rv0); end
        checks++;
        if (fe_count - fe0 !== 0) begin errors++; $display("FAIL midrst_frameerr: got %0d expected 0", fe_count - fe0); end
        @(posedge src_clk);
        #1;
        send_frame(8'h09, 1'b1, 1'b1);
        drive_level(1'b1, 12);
        check_received("midrst_next", rv0, 1, 8'h09, {7'b1000000, 7'b1000000, 7'b0010000});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_normal_byte();
        test_back_to_back();
        test_start_glitch();
        test_frame_error();
        test_reset_mid_frame();
        @(negedge src_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
